// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : vga_timing_pkg
//  Purpose : Line constants for the 800x600 SVGA frame, shared by the timing
//            generator, the game logic and the vblank update scheduler.
//            Also holds the update-scheduler FSM state encoding.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

    // First line that is not visible; vertical blanking starts here.
    localparam logic [9:0] VISIBLE_LINES = 10'd600;
    // Total lines per frame, including blanking.
    localparam logic [9:0] FRAME_LINES   = 10'd628;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        PICK    = 2'd1,
        GRANTED = 2'd2
    } state_t;

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vblank_update_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module  : rr_pick
//  Purpose : Combinational round-robin priority finder. Returns the first set
//            bit of elig, searching ptr, ptr+1, ... wrapping modulo N.
//  Ports   : elig  [N-1:0]      candidate mask
//            ptr   [PTR_W-1:0]  search start index (must be < N)
//            valid              at least one candidate present
//            index [PTR_W-1:0]  index of the chosen candidate
//  Rev     : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     elig,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [PTR_W-1:0] index
);

    logic [PTR_W-1:0] w_idx;

    // Walk the offsets from farthest to nearest so the nearest hit to ptr is
    // the last assignment and therefore wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        w_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = PTR_W'((int'(ptr) + i) % N);
            if (elig[w_idx]) begin
                valid = 1'b1;
                index = w_idx;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/vblank_update_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : vblank_update_scheduler
//  Purpose : Opens an update window once per frame during vertical blanking
//            and grants exclusive update access to up to NUM_REQ requesters,
//            round-robin, at most once each per window.
//  Ports   : CLK          pixel clock (40 MHz)
//            RESET        synchronous active-high reset
//            Y_PIXEL[9:0] current line from the SVGA timing generator
//            REQ[N-1:0]   level update requests
//            DONE[N-1:0]  one-cycle completion pulse from the grantee
//            GRANT[N-1:0] registered one-hot (or zero) grant
//            WINDOW_OPEN  registered, high while the FSM is not in WAIT
//            OVERRUN      one-cycle pulse when window close revokes a grant
//            FRAME_COUNT  number of window openings, wraps at 16 bits
//  Rev     : 1.0  initial release
// ============================================================================
module vblank_update_scheduler #(
    parameter int         NUM_REQ       = 4,
    parameter logic [9:0] VISIBLE_LINES = vga_timing_pkg::VISIBLE_LINES,
    parameter logic [9:0] FRAME_LINES   = vga_timing_pkg::FRAME_LINES,
    parameter logic [9:0] GUARD_LINES   = 10'd2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [9:0]         Y_PIXEL,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [NUM_REQ-1:0] DONE,
    output logic [NUM_REQ-1:0] GRANT,
    output logic               WINDOW_OPEN,
    output logic               OVERRUN,
    output logic [15:0]        FRAME_COUNT
);

    import vga_timing_pkg::*;

    localparam int               PTR_W        = $clog2(NUM_REQ);
    localparam logic [9:0]       c_CLOSE_LINE = FRAME_LINES - GUARD_LINES;
    localparam logic [NUM_REQ-1:0] c_ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] c_LAST_IDX   = PTR_W'(NUM_REQ - 1);

    state_t             r_state;
    logic               r_open_q;
    logic [NUM_REQ-1:0] r_served;
    logic [NUM_REQ-1:0] r_grant;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_cur;
    logic               r_window_open;
    logic               r_overrun;
    logic [15:0]        r_frame_count;

    logic               w_in_win;
    logic               w_open_edge;
    logic [NUM_REQ-1:0] w_elig;
    logic               w_pick_valid;
    logic [PTR_W-1:0]   w_pick_idx;
    logic [PTR_W-1:0]   w_next_ptr;

    assign w_in_win    = (Y_PIXEL >= VISIBLE_LINES) && (Y_PIXEL < c_CLOSE_LINE);
    // r_open_q resets high so a reset taken inside the window cannot fake a
    // rising edge; the scheduler then waits for the next frame's window.
    assign w_open_edge = w_in_win & ~r_open_q;
    assign w_elig      = REQ & ~r_served;
    assign w_next_ptr  = (r_cur == c_LAST_IDX) ? '0 : r_cur + 1'b1;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .elig  (w_elig),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .index (w_pick_idx)
    );

    // WINDOW_OPEN is assigned in every branch as (next state != WAIT).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= WAIT;
            r_open_q      <= 1'b1;
            r_served      <= '0;
            r_grant       <= '0;
            r_ptr         <= '0;
            r_cur         <= '0;
            r_window_open <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_open_q  <= w_in_win;
            r_overrun <= 1'b0;
            case (r_state)
                WAIT: begin
                    if (w_open_edge) begin
                        r_served      <= '0;
                        r_frame_count <= r_frame_count + 16'd1;
                        r_state       <= PICK;
                        r_window_open <= 1'b1;
                    end else begin
                        r_window_open <= 1'b0;
                    end
                end
                PICK: begin
                    if (!w_in_win) begin
                        r_state       <= WAIT;
                        r_window_open <= 1'b0;
                    end else begin
                        r_window_open <= 1'b1;
                        if (w_pick_valid) begin
                            r_grant <= c_ONE << w_pick_idx;
                            r_cur   <= w_pick_idx;
                            r_state <= GRANTED;
                        end
                    end
                end
                GRANTED: begin
                    // Completion takes priority over window close.
                    if (DONE[r_cur]) begin
                        r_grant         <= '0;
                        r_served[r_cur] <= 1'b1;
                        r_ptr           <= w_next_ptr;
                        if (w_in_win) begin
                            r_state       <= PICK;
                            r_window_open <= 1'b1;
                        end else begin
                            r_state       <= WAIT;
                            r_window_open <= 1'b0;
                        end
                    end else if (!w_in_win) begin
                        r_grant         <= '0;
                        r_overrun       <= 1'b1;
                        r_served[r_cur] <= 1'b1;
                        r_ptr           <= w_next_ptr;
                        r_state         <= WAIT;
                        r_window_open   <= 1'b0;
                    end else begin
                        r_window_open <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= WAIT;
                    r_grant       <= '0;
                    r_window_open <= 1'b0;
                end
            endcase
        end
    end

    assign GRANT       = r_grant;
    assign WINDOW_OPEN = r_window_open;
    assign OVERRUN     = r_overrun;
    assign FRAME_COUNT = r_frame_count;

endmodule : vblank_update_scheduler
`default_nettype wire

// File: tb/tb_vblank_update_scheduler.sv
`default_nettype none
// ============================================================================
//  Module  : tb_vblank_update_scheduler
//  Purpose : Self-checking bench for vblank_update_scheduler. Expected grants
//            and overrun pulses are queued by the stimulus and popped by an
//            independent monitor whenever the DUT presents them.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_vblank_update_scheduler;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [9:0]  Y_PIXEL;
    logic [3:0]  REQ;
    logic [3:0]  DONE;
    logic [3:0]  GRANT;
    logic        WINDOW_OPEN;
    logic        OVERRUN;
    logic [15:0] FRAME_COUNT;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_grant_q[$];
    int         exp_ovr_q[$];

    bit done_en   = 1'b1;
    int done_wait = 2;

    vblank_update_scheduler #(
        .NUM_REQ       (4),
        .VISIBLE_LINES (10'd600),
        .FRAME_LINES   (10'd628),
        .GUARD_LINES   (10'd2)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .Y_PIXEL     (Y_PIXEL),
        .REQ         (REQ),
        .DONE        (DONE),
        .GRANT       (GRANT),
        .WINDOW_OPEN (WINDOW_OPEN),
        .OVERRUN     (OVERRUN),
        .FRAME_COUNT (FRAME_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    // One line per clock: present the line, let the DUT sample it, step past the edge.
    task automatic drive_line(input int y);
        Y_PIXEL = 10'(y);
        @(posedge CLK);
        #1;
    endtask

    task automatic sweep(input int a, input int b);
        for (int y = a; y <= b; y++) drive_line(y);
    endtask

    task automatic push_grants(input logic [3:0] g0, input logic [3:0] g1,
                               input logic [3:0] g2, input logic [3:0] g3, input int n);
        if (n > 0) exp_grant_q.push_back(g0);
        if (n > 1) exp_grant_q.push_back(g1);
        if (n > 2) exp_grant_q.push_back(g2);
        if (n > 3) exp_grant_q.push_back(g3);
    endtask

    // Requester model: pulses DONE for the granted bit done_wait+1 edges after the grant.
    initial begin
        logic [3:0] g;
        DONE = 4'b0000;
        forever begin
            @(negedge CLK);
            if (GRANT != 4'b0000) begin
                g = GRANT;
                if (done_en) begin
                    repeat (done_wait) @(posedge CLK);
                    #1;
                    DONE = g;
                    @(posedge CLK);
                    #1;
                    DONE = 4'b0000;
                end else begin
                    while (GRANT != 4'b0000) @(negedge CLK);
                end
            end
        end
    end

    // Monitor: every new grant and every overrun pulse must match the queue head.
    initial begin
        logic [3:0] prev;
        prev = 4'b0000;
        forever begin
            @(negedge CLK);
            if (GRANT != 4'b0000 && GRANT != prev) begin
                if (exp_grant_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_order: got %b, required no grant", GRANT);
                end else begin
                    check("grant_order", 32'(GRANT), 32'(exp_grant_q.pop_front()));
                end
            end
            if (OVERRUN) begin
                if (exp_ovr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL overrun_pulse: got pulse at frame %0d, required none", FRAME_COUNT);
                end else begin
                    check("overrun_frame", 32'(FRAME_COUNT), 32'(exp_ovr_q.pop_front()));
                end
            end
            prev = GRANT;
        end
    end

    initial begin
        RESET   = 1'b1;
        Y_PIXEL = 10'd0;
        REQ     = 4'b0000;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_grant",   32'(GRANT),       32'h0);
        check("reset_window",  32'(WINDOW_OPEN), 32'h0);
        check("reset_overrun", 32'(OVERRUN),     32'h0);
        check("reset_frames",  32'(FRAME_COUNT), 32'h0);
        RESET = 1'b0;

        // Frame 1: no requests, window timing only.
        for (int y = 0; y <= 627; y++) begin
            drive_line(y);
            if (y == 599) check("win_before_open", 32'(WINDOW_OPEN), 32'h0);
            if (y == 600) check("win_open",        32'(WINDOW_OPEN), 32'h1);
            if (y == 625) check("win_last",        32'(WINDOW_OPEN), 32'h1);
            if (y == 626) check("win_closed",      32'(WINDOW_OPEN), 32'h0);
        end
        check("f1_frames", 32'(FRAME_COUNT), 32'h1);
        check("f1_grant",  32'(GRANT),       32'h0);

        // Frame 2: all requesting, ptr=0.
        REQ = 4'b1111;
        push_grants(4'b0001, 4'b0010, 4'b0100, 4'b1000, 4);
        sweep(0, 599);
        drive_line(600);
        check("grant_in_pick", 32'(GRANT), 32'h0);
        drive_line(601);
        check("grant_latency", 32'(GRANT), 32'h1);
        sweep(602, 620);
        check("rr_idle_grant", 32'(GRANT), 32'h0);
        check("rr_all_served", 32'(exp_grant_q.size()), 32'h0);
        sweep(621, 627);
        check("f2_frames", 32'(FRAME_COUNT), 32'h2);

        // Frames 3 and 4: frame 3 ends with 0010 completed, so ptr=2 in frame 4.
        REQ = 4'b0011;
        push_grants(4'b0001, 4'b0010, 4'b0000, 4'b0000, 2);
        sweep(0, 627);
        check("f3_served", 32'(exp_grant_q.size()), 32'h0);
        push_grants(4'b0001, 4'b0010, 4'b0000, 4'b0000, 2);
        sweep(0, 627);
        check("ptr_carry_served", 32'(exp_grant_q.size()), 32'h0);

        // Frame 5: ptr=2 with everyone requesting, order must wrap.
        REQ = 4'b1111;
        push_grants(4'b0100, 4'b1000, 4'b0001, 4'b0010, 4);
        sweep(0, 627);
        check("ptr_wrap_served", 32'(exp_grant_q.size()), 32'h0);

        // Frame 6: grantee never completes, window close revokes it.
        REQ     = 4'b0100;
        done_en = 1'b0;
        push_grants(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1);
        exp_ovr_q.push_back(6);
        sweep(0, 625);
        check("ovr_held",        32'(GRANT),   32'h4);
        check("ovr_not_yet",     32'(OVERRUN), 32'h0);
        drive_line(626);
        check("ovr_grant_drop",  32'(GRANT),       32'h0);
        check("ovr_pulse",       32'(OVERRUN),     32'h1);
        check("ovr_window",      32'(WINDOW_OPEN), 32'h0);
        drive_line(627);
        check("ovr_one_cycle",   32'(OVERRUN),     32'h0);
        check("ovr_seen",        32'(exp_ovr_q.size()), 32'h0);

        // Frame 7: the overrun requester is eligible again.
        done_en = 1'b1;
        push_grants(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1);
        sweep(0, 627);
        check("ovr_reeligible", 32'(exp_grant_q.size()), 32'h0);

        // Frame 8: DONE sampled on the same edge as Y=626.
        done_wait = 24;
        push_grants(4'b0100, 4'b0000, 4'b0000, 4'b0000, 1);
        sweep(0, 625);
        check("sim_held",      32'(GRANT),       32'h4);
        drive_line(626);
        check("sim_no_ovr",    32'(OVERRUN),     32'h0);
        check("sim_grant",     32'(GRANT),       32'h0);
        check("sim_wait",      32'(WINDOW_OPEN), 32'h0);
        drive_line(627);
        check("sim_no_ovr_2",  32'(OVERRUN),     32'h0);
        done_wait = 2;

        // Frame 9: reset at Y=610 while granted.
        REQ     = 4'b1000;
        done_en = 1'b0;
        push_grants(4'b1000, 4'b0000, 4'b0000, 4'b0000, 1);
        sweep(0, 609);
        check("rst_pre_grant", 32'(GRANT), 32'h8);
        Y_PIXEL = 10'd610;
        RESET   = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_grant",   32'(GRANT),       32'h0);
        check("rst_overrun", 32'(OVERRUN),     32'h0);
        check("rst_frames",  32'(FRAME_COUNT), 32'h0);
        check("rst_window",  32'(WINDOW_OPEN), 32'h0);
        RESET = 1'b0;
        sweep(611, 627);
        check("rst_no_grant",    32'(GRANT),       32'h0);
        check("rst_frames_hold", 32'(FRAME_COUNT), 32'h0);

        done_en = 1'b1;
        push_grants(4'b1000, 4'b0000, 4'b0000, 4'b0000, 1);
        sweep(0, 599);
        check("rst_frames_pre", 32'(FRAME_COUNT), 32'h0);
        drive_line(600);
        check("rst_frames_new", 32'(FRAME_COUNT), 32'h1);
        check("rst_win_new",    32'(WINDOW_OPEN), 32'h1);
        sweep(601, 627);
        check("rst_regrant", 32'(exp_grant_q.size()), 32'h0);
        check("ovr_queue",   32'(exp_ovr_q.size()),   32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_vblank_update_scheduler
`default_nettype wire
